// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcodes, functs,
// controller state codes and the ALU operation encoding.
package multicycle_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  // Encoding matches the existing single-cycle ALU control lines.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  function automatic logic funct_legal(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

  function automatic logic [3:0] funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: add/sub/and/or and signed set-less-than, plus zero flag.
module mc_alu
  import multicycle_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset core: controller FSM, register file and next-PC logic,
// with req/ack instruction and data memory ports.
module multicycle_datapath
  import multicycle_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              NUM_REGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter logic [5:0]      HALT_OPCODE = 6'h3F
) (
  input  logic            Clk,
  input  logic            Reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  input  logic [4:0]      DebugSel,
  output logic [XLEN-1:0] DebugReg,
  output logic            Halted,
  output logic            Fault,
  output logic [31:0]     RetireCount
);

  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [2:0]      state;
  logic [XLEN-1:0] pc;
  logic [31:0]     ir;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] mdr;
  logic            fault;
  logic [31:0]     retire_count;
  logic [XLEN-1:0] regs [NUM_REGS];

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];

  // pc already holds PC+4 once the fetch has completed.
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] j_target;

  assign imm_sext  = {{(XLEN-16){ir[15]}}, ir[15:0]};
  assign br_target = pc + (imm_sext << 2);
  assign j_target  = {pc[XLEN-1:28], ir[25:0], 2'b00};

  function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx);
    if (int'(idx) < NUM_REGS) return regs[idx[RIDX_W-1:0]];
    return '0;
  endfunction

  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_y;
  logic            alu_zero;

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = imm_sext;
    if (opcode == OP_RTYPE) begin
      alu_op = funct_to_alu(funct);
      alu_b  = b_reg;
    end else if (opcode == OP_BEQ) begin
      alu_op = ALU_SUB;
      alu_b  = b_reg;
    end
  end

  mc_alu #(.XLEN(XLEN)) u_alu (
    .a    (a_reg),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_zero)
  );

  logic op_legal;
  logic is_mem;

  always_comb begin
    case (opcode)
      OP_RTYPE:                          op_legal = funct_legal(funct);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
  end

  assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);

  logic [4:0]      wb_idx;
  logic [XLEN-1:0] wb_data;
  logic            wb_en;

  assign wb_idx  = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_data = (opcode == OP_LW) ? mdr : alu_out;
  assign wb_en   = (state == ST_WB) && (wb_idx != 5'd0) && (int'(wb_idx) < NUM_REGS);

  // Controller: state, PC, fault flag and retire counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= ST_FETCH;
      pc           <= RESET_PC;
      fault        <= 1'b0;
      retire_count <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            pc    <= pc + XLEN'(4);
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (opcode == HALT_OPCODE) begin
            state <= ST_HALT;
          end else if (!op_legal) begin
            state <= ST_HALT;
            fault <= 1'b1;
          end else if (opcode == OP_J) begin
            pc           <= j_target;
            retire_count <= retire_count + 32'd1;
            state        <= ST_FETCH;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (opcode == OP_BEQ) begin
            if (alu_zero) pc <= br_target;
            retire_count <= retire_count + 32'd1;
            state        <= ST_FETCH;
          end else if (is_mem) begin
            if (alu_y[1:0] != 2'b00) begin
              state <= ST_HALT;
              fault <= 1'b1;
            end else begin
              state <= ST_MEM;
            end
          end else begin
            state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            if (opcode == OP_SW) begin
              retire_count <= retire_count + 32'd1;
              state        <= ST_FETCH;
            end else begin
              state <= ST_WB;
            end
          end
        end
        ST_WB: begin
          retire_count <= retire_count + 32'd1;
          state        <= ST_FETCH;
        end
        ST_HALT: ;
        default: begin
          state <= ST_HALT;
          fault <= 1'b1;
        end
      endcase
    end
  end

  // Datapath latches carry no reset; the controller never consumes them stale.
  always_ff @(posedge Clk) begin
    if (state == ST_FETCH && imem_ack) ir <= imem_rdata;
    if (state == ST_DECODE) begin
      a_reg <= read_reg(rs);
      b_reg <= read_reg(rt);
    end
    if (state == ST_EXEC) alu_out <= alu_y;
    if (state == ST_MEM && dmem_ack) mdr <= dmem_rdata;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_idx[RIDX_W-1:0]] <= wb_data;
    end
  end

  assign imem_req    = (state == ST_FETCH) && !Reset;
  assign imem_addr   = pc;
  assign dmem_req    = (state == ST_MEM) && !Reset;
  assign dmem_we     = (opcode == OP_SW);
  assign dmem_addr   = alu_out;
  assign dmem_wdata  = b_reg;
  assign DebugReg    = read_reg(DebugSel);
  assign Halted      = (state == ST_HALT);
  assign Fault       = fault;
  assign RetireCount = retire_count;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed and randomized checks of multicycle_datapath against an
// instruction-level reference model with wait-state memory responders.
module tb_multicycle_datapath;

  localparam logic [31:0] HALT_W = 32'hFC000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Core A: XLEN=32, NUM_REGS=32
  logic        rst_a = 1'b1;
  logic        imem_req_a, dmem_req_a, dmem_we_a, halted_a, fault_a;
  logic [31:0] imem_addr_a, dmem_addr_a, dmem_wdata_a, dbgreg_a, retire_a;
  logic [31:0] imem_rdata_a = '0;
  logic [31:0] dmem_rdata_a = '0;
  logic        imem_ack_a = 1'b0;
  logic        dmem_ack_a = 1'b0;
  logic [4:0]  dbg_a = '0;

  // Core B: XLEN=64, NUM_REGS=16
  logic        rst_b = 1'b1;
  logic        imem_req_b, dmem_req_b, dmem_we_b, halted_b, fault_b;
  logic [63:0] imem_addr_b, dmem_addr_b, dmem_wdata_b, dbgreg_b;
  logic [31:0] retire_b;
  logic [31:0] imem_rdata_b = '0;
  logic [63:0] dmem_rdata_b = '0;
  logic        imem_ack_b = 1'b0;
  logic        dmem_ack_b = 1'b0;
  logic [4:0]  dbg_b = '0;

  multicycle_datapath #(.XLEN(32), .NUM_REGS(32)) dut_a (
    .Clk(clk), .Reset(rst_a),
    .imem_req(imem_req_a), .imem_addr(imem_addr_a), .imem_rdata(imem_rdata_a), .imem_ack(imem_ack_a),
    .dmem_req(dmem_req_a), .dmem_we(dmem_we_a), .dmem_addr(dmem_addr_a), .dmem_wdata(dmem_wdata_a),
    .dmem_rdata(dmem_rdata_a), .dmem_ack(dmem_ack_a),
    .DebugSel(dbg_a), .DebugReg(dbgreg_a), .Halted(halted_a), .Fault(fault_a), .RetireCount(retire_a)
  );

  multicycle_datapath #(.XLEN(64), .NUM_REGS(16)) dut_b (
    .Clk(clk), .Reset(rst_b),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b), .imem_ack(imem_ack_b),
    .dmem_req(dmem_req_b), .dmem_we(dmem_we_b), .dmem_addr(dmem_addr_b), .dmem_wdata(dmem_wdata_b),
    .dmem_rdata(dmem_rdata_b), .dmem_ack(dmem_ack_b),
    .DebugSel(dbg_b), .DebugReg(dbgreg_b), .Halted(halted_b), .Fault(fault_b), .RetireCount(retire_b)
  );

  logic [31:0] imem_a [256];
  logic [31:0] dmem_a [256];
  logic [31:0] imem_b [16];
  int iw_a = 0;
  int dw_a = 0;
  int icnt = 0;
  int dcnt = 0;
  logic late_ack = 1'b0;

  // Memory responders: ack after the configured number of wait cycles.
  always @(negedge clk) begin
    if (imem_req_a) begin
      imem_ack_a   = (icnt == iw_a);
      imem_rdata_a = imem_a[imem_addr_a[9:2]];
      icnt++;
    end else begin
      imem_ack_a = 1'b0;
      icnt = 0;
    end
    if (dmem_req_a) begin
      dmem_ack_a   = (dcnt == dw_a);
      dmem_rdata_a = dmem_a[dmem_addr_a[9:2]];
      if (dmem_ack_a && dmem_we_a) dmem_a[dmem_addr_a[9:2]] = dmem_wdata_a;
      dcnt++;
    end else begin
      dmem_ack_a   = late_ack;
      dmem_rdata_a = 32'hDEADBEEF;
      dcnt = 0;
    end
    imem_ack_b   = imem_req_b;
    imem_rdata_b = imem_b[imem_addr_b[5:2]];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem_a[i] = HALT_W;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    late_ack = 1'b0;
    step();
    step();
    rst_a = 1'b0;
  endtask

  task automatic run_a(input int bound, output int cyc);
    cyc = 0;
    while (halted_a !== 1'b1 && cyc < bound) begin
      step();
      cyc++;
    end
    chk("run_halted", 64'(halted_a), 64'd1);
  endtask

  task automatic wait_dreq(input string tag, input int bound);
    int n = 0;
    while (dmem_req_a !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk(tag, 64'(dmem_req_a), 64'd1);
  endtask

  // Instruction-level reference model.
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [256];
  int          m_cycles;
  int          m_retire;
  logic        m_fault;

  task automatic model_run();
    logic [31:0] pc, w, a, b, se, addr, res;
    logic [5:0]  op, fn;
    int rs, rt, rd;
    bit done, bad;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    pc = '0; m_cycles = 0; m_retire = 0; m_fault = 1'b0; done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      w  = imem_a[pc[9:2]];
      op = w[31:26]; fn = w[5:0];
      rs = int'(w[25:21]); rt = int'(w[20:16]); rd = int'(w[15:11]);
      a  = m_regs[rs]; b = m_regs[rt];
      se = {{16{w[15]}}, w[15:0]};
      m_cycles += iw_a;
      pc = pc + 32'd4;
      case (op)
        6'h00: begin
          bad = 0; res = '0;
          case (fn)
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: bad = 1;
          endcase
          if (bad) begin m_fault = 1'b1; m_cycles += 2; done = 1; end
          else begin if (rd != 0) m_regs[rd] = res; m_cycles += 4; m_retire++; end
        end
        6'h08: begin if (rt != 0) m_regs[rt] = a + se; m_cycles += 4; m_retire++; end
        6'h23, 6'h2B: begin
          addr = a + se;
          if (addr[1:0] != 2'b00) begin m_fault = 1'b1; m_cycles += 3; done = 1; end
          else if (op == 6'h23) begin
            if (rt != 0) m_regs[rt] = m_dmem[addr[9:2]];
            m_cycles += 5 + dw_a; m_retire++;
          end else begin
            m_dmem[addr[9:2]] = b;
            m_cycles += 4 + dw_a; m_retire++;
          end
        end
        6'h04: begin if (a == b) pc = pc + (se << 2); m_cycles += 3; m_retire++; end
        6'h02: begin pc = {pc[31:28], w[25:0], 2'b00}; m_cycles += 2; m_retire++; end
        6'h3F: begin m_cycles += 2; done = 1; end
        default: begin m_fault = 1'b1; m_cycles += 2; done = 1; end
      endcase
    end
  endtask

  task automatic gen_prog(input int n);
    logic [5:0] fns [5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    clear_imem();
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 9: imem_a[i] = enc_i(6'h08, int'($urandom_range(0, 7)), int'($urandom_range(1, 7)), int'($urandom_range(0, 65535)));
        2, 3, 4: imem_a[i] = enc_r(fns[$urandom_range(0, 4)], int'($urandom_range(0, 7)),
                                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        5: imem_a[i] = enc_i(6'h2B, 0, int'($urandom_range(0, 7)), 4 * int'($urandom_range(0, 31)));
        6: imem_a[i] = enc_i(6'h23, 0, int'($urandom_range(1, 7)), 4 * int'($urandom_range(0, 31)));
        7: imem_a[i] = enc_i(6'h04, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1);
        default: imem_a[i] = {6'h02, 26'(i + 2)};
      endcase
    end
  endtask

  initial begin
    int cyc, len;
    bit stable, seen;

    // Two back-to-back addi with zero-wait memories
    clear_imem();
    imem_a[0] = enc_i(6'h08, 0, 8, 5);
    imem_a[1] = enc_i(6'h08, 8, 16, -7);
    for (int i = 0; i < 256; i++) dmem_a[i] = '0;
    step();
    chk("reset_imem_req", 64'(imem_req_a), 64'd0);
    chk("reset_dmem_req", 64'(dmem_req_a), 64'd0);
    chk("reset_halted", 64'(halted_a), 64'd0);
    chk("reset_fault", 64'(fault_a), 64'd0);
    chk("reset_retire", 64'(retire_a), 64'd0);
    chk("reset_pc", 64'(imem_addr_a), 64'd0);
    rst_a = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("addi_retire_at_8", 64'(retire_a), 64'd2);
    dbg_a = 5'd16; #1;
    chk("addi_r16", 64'(dbgreg_a), 64'hFFFFFFFE);
    dbg_a = 5'd8; #1;
    chk("addi_r8", 64'(dbgreg_a), 64'd5);

    // Store then load through a 3-wait-state data memory
    clear_imem();
    imem_a[0] = enc_i(6'h08, 0, 8, 5);
    imem_a[1] = enc_i(6'h2B, 0, 8, 16);
    imem_a[2] = enc_i(6'h23, 0, 17, 16);
    dmem_a[4] = '0;
    iw_a = 0; dw_a = 3;
    reset_a();
    wait_dreq("sw_req_seen", 50);
    chk("sw_we", 64'(dmem_we_a), 64'd1);
    chk("sw_addr", 64'(dmem_addr_a), 64'h10);
    chk("sw_wdata", 64'(dmem_wdata_a), 64'd5);
    len = 0; stable = 1;
    while (dmem_req_a === 1'b1 && len < 20) begin
      stable &= (dmem_addr_a == 32'h10) && (dmem_wdata_a == 32'd5) && (dmem_we_a == 1'b1);
      len++; step();
    end
    chk("sw_req_len", 64'(len), 64'd4);
    chk("sw_stable", 64'(stable), 64'd1);
    wait_dreq("lw_req_seen", 50);
    chk("lw_we", 64'(dmem_we_a), 64'd0);
    chk("lw_addr", 64'(dmem_addr_a), 64'h10);
    len = 0;
    while (dmem_req_a === 1'b1 && len < 20) begin len++; step(); end
    chk("lw_req_len", 64'(len), 64'd4);
    run_a(50, cyc);
    dbg_a = 5'd17; #1;
    chk("lw_r17", 64'(dbgreg_a), 64'd5);
    chk("sw_mem", 64'(dmem_a[4]), 64'd5);
    chk("lwsw_retire", 64'(retire_a), 64'd3);

    // beq $0,$0,-1 spins on address 0 every 3 cycles
    clear_imem();
    imem_a[0] = enc_i(6'h04, 0, 0, -1);
    iw_a = 0; dw_a = 0;
    reset_a();
    for (int k = 1; k <= 3; k++) begin
      step(); step(); step();
      chk($sformatf("beq_pass%0d_req", k), 64'(imem_req_a), 64'd1);
      chk($sformatf("beq_pass%0d_pc", k), 64'(imem_addr_a), 64'd0);
      chk($sformatf("beq_pass%0d_retire", k), 64'(retire_a), 64'(k));
    end

    // Clean halt, illegal opcode, illegal funct, misaligned load
    clear_imem();
    reset_a();
    run_a(20, cyc);
    chk("halt_cycles", 64'(cyc), 64'd2);
    chk("halt_fault", 64'(fault_a), 64'd0);
    chk("halt_retire", 64'(retire_a), 64'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin step(); seen |= imem_req_a; end
    chk("halt_no_req", 64'(seen), 64'd0);

    imem_a[0] = 32'hF8000000;
    reset_a();
    run_a(20, cyc);
    chk("illegal_op_fault", 64'(fault_a), 64'd1);
    chk("illegal_op_retire", 64'(retire_a), 64'd0);

    imem_a[0] = enc_r(6'h21, 1, 2, 3);
    reset_a();
    run_a(20, cyc);
    chk("illegal_fn_fault", 64'(fault_a), 64'd1);

    imem_a[0] = enc_i(6'h08, 0, 1, 32'h13);
    imem_a[1] = enc_i(6'h23, 1, 2, 0);
    reset_a();
    run_a(40, cyc);
    chk("misalign_fault", 64'(fault_a), 64'd1);
    chk("misalign_retire", 64'(retire_a), 64'd1);
    chk("misalign_cycles", 64'(cyc), 64'd7);
    chk("misalign_no_dreq", 64'(dmem_req_a), 64'd0);

    // Reset during a held load, with a stray ack the cycle after Reset
    clear_imem();
    imem_a[0] = enc_i(6'h08, 0, 8, 5);
    imem_a[1] = enc_i(6'h23, 0, 9, 16);
    dmem_a[4] = 32'h00001234;
    iw_a = 0; dw_a = 10;
    reset_a();
    wait_dreq("rst_dreq_seen", 50);
    step();
    chk("rst_dreq_held", 64'(dmem_req_a), 64'd1);
    rst_a = 1'b1; #1;
    chk("rst_cycle_dreq", 64'(dmem_req_a), 64'd0);
    chk("rst_cycle_ireq", 64'(imem_req_a), 64'd0);
    imem_a[0] = HALT_W;
    imem_a[1] = HALT_W;
    step();
    rst_a = 1'b0;
    late_ack = 1'b1;
    chk("rst_pc_reload", 64'(imem_addr_a), 64'd0);
    step();
    late_ack = 1'b0;
    run_a(20, cyc);
    chk("rst_fault", 64'(fault_a), 64'd0);
    chk("rst_retire", 64'(retire_a), 64'd0);
    dbg_a = 5'd9; #1;
    chk("rst_r9", 64'(dbgreg_a), 64'd0);
    dbg_a = 5'd8; #1;
    chk("rst_r8", 64'(dbgreg_a), 64'd0);

    // Random programs against the reference model
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 256; i++) begin
        dmem_a[i] = $urandom;
        m_dmem[i] = dmem_a[i];
      end
      iw_a = int'($urandom_range(0, 2));
      dw_a = int'($urandom_range(0, 2));
      gen_prog(14);
      model_run();
      reset_a();
      run_a(2000, cyc);
      chk($sformatf("rand%0d_cycles", p), 64'(cyc), 64'(m_cycles));
      chk($sformatf("rand%0d_retire", p), 64'(retire_a), 64'(m_retire));
      chk($sformatf("rand%0d_fault", p), 64'(fault_a), 64'(m_fault));
      for (int r = 0; r < 8; r++) begin
        dbg_a = 5'(r); #1;
        chk($sformatf("rand%0d_r%0d", p, r), 64'(dbgreg_a), 64'(m_regs[r]));
      end
      for (int w = 0; w < 32; w++)
        chk($sformatf("rand%0d_mem%0d", p, w), 64'(dmem_a[w]), 64'(m_dmem[w]));
    end

    // 64-bit core with 16 registers
    for (int i = 0; i < 16; i++) imem_b[i] = HALT_W;
    imem_b[0] = enc_i(6'h08, 0, 1, 1);
    imem_b[1] = enc_r(6'h22, 0, 1, 2);
    imem_b[2] = enc_i(6'h08, 0, 20, 7);
    step();
    rst_b = 1'b0;
    cyc = 0;
    while (halted_b !== 1'b1 && cyc < 100) begin step(); cyc++; end
    chk("x64_halted", 64'(halted_b), 64'd1);
    chk("x64_fault", 64'(fault_b), 64'd0);
    chk("x64_retire", 64'(retire_b), 64'd3);
    dbg_b = 5'd2; #1;
    chk("x64_sub", dbgreg_b, 64'hFFFF_FFFF_FFFF_FFFF);
    dbg_b = 5'd1; #1;
    chk("x64_r1", dbgreg_b, 64'd1);
    dbg_b = 5'd4; #1;
    chk("x64_alias_r4", dbgreg_b, 64'd0);
    dbg_b = 5'd20; #1;
    chk("x64_dbg20", dbgreg_b, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
